// File: rtl/mem_read_arbiter_if.sv
// Burst read channel: control (go/base/length/done) plus streaming user words.
// The requester side uses modport master; the side that serves bursts uses slave.
interface mem_read_arbiter_if #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned DATA_W = 32
);
    logic              control_go;
    logic [ADDR_W-1:0] control_base;
    logic [ADDR_W-1:0] control_length;
    logic              control_done;
    logic              user_available;
    logic              user_re;
    logic [DATA_W-1:0] user_data;

    modport master (
        output control_go, control_base, control_length, user_re,
        input  control_done, user_available, user_data
    );

    modport slave (
        input  control_go, control_base, control_length, user_re,
        output control_done, user_available, user_data
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Shares one memory burst-read master between the i-cache and d-cache ports.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the d-cache wins ties.
module mem_read_arbiter #(
    parameter int unsigned ADDR_W = 26,
    parameter int unsigned DATA_W = 32
) (
    input logic               clk,
    input logic               rst,
    mem_read_arbiter_if.slave  ic,
    mem_read_arbiter_if.slave  dc,
    mem_read_arbiter_if.master mem
);

    typedef enum logic [1:0] {StIdle, StIssue, StBurst} state_e;

    state_e            state_q, state_d;
    logic              ic_slot_q, dc_slot_q;
    logic [ADDR_W-1:0] ic_base_q, ic_len_q, dc_base_q, dc_len_q;
    logic              owner_q, owner_d;  // 1: d-cache owns the current burst
    logic              go_q, go_d;
    logic [ADDR_W-1:0] base_q, base_d, len_q, len_d, cnt_q, cnt_d;
    logic              grant_dc, free_slot, burst_re, fire;
    logic [DATA_W-1:0] rd_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dc_q;  // winner of the most recent tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dc_q <= 1'b0;
        end else if (state_q == StIdle && mem.control_done && ic_slot_q && dc_slot_q) begin
            last_dc_q <= grant_dc;
        end
    end
    assign grant_dc = (ic_slot_q && dc_slot_q) ? !last_dc_q : dc_slot_q;
`else
    assign grant_dc = dc_slot_q;
`endif

    assign burst_re = (state_q == StBurst) && (owner_q ? dc.user_re : ic.user_re);
    assign fire     = burst_re && mem.user_available;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        go_d      = 1'b0;
        base_d    = base_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        free_slot = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((ic_slot_q || dc_slot_q) && mem.control_done) begin
                    state_d = StIssue;
                    owner_d = grant_dc;
                    go_d    = 1'b1;
                    base_d  = grant_dc ? dc_base_q : ic_base_q;
                    len_d   = grant_dc ? dc_len_q : ic_len_q;
                end
            end
            StIssue: state_d = StBurst;
            StBurst: begin
                if (fire) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
                // Also ends a sub-word burst (length < 4) without waiting for data.
                if (cnt_d == (len_q >> 2)) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    free_slot = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            go_q    <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            go_q    <= go_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ic_slot_q <= 1'b0;
            ic_base_q <= '0;
            ic_len_q  <= '0;
            dc_slot_q <= 1'b0;
            dc_base_q <= '0;
            dc_len_q  <= '0;
        end else begin
            assert (!(ic.control_go && ic_slot_q))
            else $error("mem_read_arbiter: ic go while busy, ignored");
            assert (!(dc.control_go && dc_slot_q))
            else $error("mem_read_arbiter: dc go while busy, ignored");

            if (ic.control_go && !ic_slot_q && ic.control_length != '0) begin
                ic_slot_q <= 1'b1;
                ic_base_q <= ic.control_base;
                ic_len_q  <= ic.control_length;
            end else if (free_slot && !owner_q) begin
                ic_slot_q <= 1'b0;
            end

            if (dc.control_go && !dc_slot_q && dc.control_length != '0) begin
                dc_slot_q <= 1'b1;
                dc_base_q <= dc.control_base;
                dc_len_q  <= dc.control_length;
            end else if (free_slot && owner_q) begin
                dc_slot_q <= 1'b0;
            end
        end
    end

    // Outputs are masked by rst so a mid-burst reset stops forwarding immediately.
    assign ic.control_done   = rst || !ic_slot_q;
    assign dc.control_done   = rst || !dc_slot_q;
    assign ic.user_available = !rst && state_q == StBurst && !owner_q && mem.user_available;
    assign dc.user_available = !rst && state_q == StBurst && owner_q && mem.user_available;
    assign rd_data           = mem.user_data;
    assign ic.user_data      = rd_data;
    assign dc.user_data      = rd_data;

    assign mem.control_go     = !rst && go_q;
    assign mem.control_base   = base_q;
    assign mem.control_length = len_q;
    assign mem.user_re        = !rst && burst_re;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter with a burst-memory model and ordered scoreboard.
module tb_mem_read_arbiter;
    localparam int unsigned ADDR_W = 26;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ic_if ();
    mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dc_if ();
    mem_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .ic  (ic_if),
        .dc  (dc_if),
        .mem (mem_if)
    );

    // Memory model: word k of a burst at base B carries B + 4k.
    logic              mem_done;
    logic              mem_flush;
    int unsigned       m_rem = 0;
    logic [DATA_W-1:0] m_data = '0;
    assign mem_if.control_done   = mem_done;
    assign mem_if.user_available = (m_rem != 0);
    assign mem_if.user_data      = m_data;
    always @(posedge clk) begin
        if (mem_flush) begin
            m_rem <= 0;
        end else if (mem_if.control_go) begin
            m_rem  <= 32'(mem_if.control_length >> 2);
            m_data <= DATA_W'(mem_if.control_base);
        end else if (mem_if.user_available && mem_if.user_re) begin
            m_rem  <= m_rem - 1;
            m_data <= m_data + 32'd4;
        end
    end

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] len;
    } iss_t;
    typedef struct packed {
        logic              port;
        logic [DATA_W-1:0] data;
    } word_t;

    iss_t  exp_iss[$];
    word_t exp_words[$];
    iss_t  mon_iss;
    word_t mon_word;
    int    n_pass  = 0;
    int    n_total = 0;
    int    n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_burst(input logic port, input int unsigned b, input int unsigned l);
        exp_iss.push_back(iss_t'{base: ADDR_W'(b), len: ADDR_W'(l)});
        for (int k = 0; k < int'(l >> 2); k++) begin
            exp_words.push_back(word_t'{port: port, data: DATA_W'(b + 4 * k)});
        end
    endtask

    task automatic pulse(input logic i_go, input int unsigned i_b, input int unsigned i_l,
                         input logic d_go, input int unsigned d_b, input int unsigned d_l);
        ic_if.control_go     = i_go;
        ic_if.control_base   = ADDR_W'(i_b);
        ic_if.control_length = ADDR_W'(i_l);
        dc_if.control_go     = d_go;
        dc_if.control_base   = ADDR_W'(d_b);
        dc_if.control_length = ADDR_W'(d_l);
        @(posedge clk);
        #1;
        ic_if.control_go = 1'b0;
        dc_if.control_go = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(ic_if.control_done && dc_if.control_done && exp_words.size() == 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ic_done"}, 64'(ic_if.control_done), 64'd1);
        chk({tag, "_dc_done"}, 64'(dc_if.control_done), 64'd1);
        chk({tag, "_words_left"}, 64'(exp_words.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ic_words(input int target, input string tag);
        int seen = 0;
        int n    = 0;
        while (seen < target && n < 40) begin
            @(negedge clk);
            n++;
            if (ic_if.user_available && ic_if.user_re) seen++;
        end
        chk(tag, 64'(seen), 64'(target));
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: issues and delivered words must come out in pushed order.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_if.control_go) begin
                if (exp_iss.size() == 0) begin
                    chk("unexpected_issue", 64'(mem_if.control_go), 64'd0);
                end else begin
                    mon_iss = exp_iss.pop_front();
                    chk("issue_base", 64'(mem_if.control_base), 64'(mon_iss.base));
                    chk("issue_len", 64'(mem_if.control_length), 64'(mon_iss.len));
                end
            end
            if ((ic_if.user_available && ic_if.user_re) || (dc_if.user_available && dc_if.user_re)) begin
                if (exp_words.size() == 0) begin
                    chk("unexpected_word", 64'({dc_if.user_available, ic_if.user_available}), 64'd0);
                end else begin
                    mon_word = exp_words.pop_front();
                    chk("word_owner", 64'({dc_if.user_available, ic_if.user_available}),
                        mon_word.port ? 64'd2 : 64'd1);
                    chk("word_data", 64'(mon_word.port ? dc_if.user_data : ic_if.user_data),
                        64'(mon_word.data));
                    chk("busy_during_word",
                        64'(mon_word.port ? dc_if.control_done : ic_if.control_done), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                  = 1'b1;
        mem_done             = 1'b1;
        mem_flush            = 1'b0;
        ic_if.control_go     = 1'b0;
        ic_if.control_base   = '0;
        ic_if.control_length = '0;
        ic_if.user_re        = 1'b1;
        dc_if.control_go     = 1'b0;
        dc_if.control_base   = '0;
        dc_if.control_length = '0;
        dc_if.user_re        = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_ic_done", 64'(ic_if.control_done), 64'd1);
        chk("rst_dc_done", 64'(dc_if.control_done), 64'd1);
        chk("rst_mem_go", 64'(mem_if.control_go), 64'd0);
        chk("rst_mem_base", 64'(mem_if.control_base), 64'd0);
        chk("rst_mem_len", 64'(mem_if.control_length), 64'd0);
        chk("rst_ic_avail", 64'(ic_if.user_available), 64'd0);
        chk("rst_dc_avail", 64'(dc_if.user_available), 64'd0);
        chk("rst_mem_re", 64'(mem_if.user_re), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single i-cache burst: go -> mem go two cycles later, four words
        expect_burst(1'b0, 'h100, 16);
        pulse(1'b1, 'h100, 16, 1'b0, 0, 0);
        @(negedge clk);
        chk("t1_ic_done_drop", 64'(ic_if.control_done), 64'd0);
        chk("t1_go_not_yet", 64'(mem_if.control_go), 64'd0);
        @(negedge clk);
        chk("t1_go_latency", 64'(mem_if.control_go), 64'd1);
        wait_idle("t1");

        // Simultaneous requests: d-cache first; round-robin alternates on the next tie
        expect_burst(1'b1, 'h300, 8);
        expect_burst(1'b0, 'h200, 8);
        pulse(1'b1, 'h200, 8, 1'b1, 'h300, 8);
        wait_idle("t2a");
`ifdef MEM_ARB_ROUND_ROBIN_EN
        expect_burst(1'b0, 'h400, 8);
        expect_burst(1'b1, 'h500, 8);
`else
        expect_burst(1'b1, 'h500, 8);
        expect_burst(1'b0, 'h400, 8);
`endif
        pulse(1'b1, 'h400, 8, 1'b1, 'h500, 8);
        wait_idle("t2b");

        // d-cache request arriving mid i-cache burst waits its turn
        expect_burst(1'b0, 'h600, 16);
        pulse(1'b1, 'h600, 16, 1'b0, 0, 0);
        wait_ic_words(2, "t3_two_words");
        ic_if.user_re = 1'b0;
        expect_burst(1'b1, 'h700, 8);
        pulse(1'b0, 0, 0, 1'b1, 'h700, 8);
        repeat (3) begin
            @(negedge clk);
            chk("t3_dc_avail_held", 64'(dc_if.user_available), 64'd0);
            chk("t3_dc_pending", 64'(dc_if.control_done), 64'd0);
            chk("t3_ic_still_owner", 64'(ic_if.user_available), 64'd1);
            @(posedge clk);
            #1;
        end
        ic_if.user_re = 1'b1;
        wait_idle("t3");

        // Reset in the middle of a burst
        expect_burst(1'b0, 'h800, 16);
        pulse(1'b1, 'h800, 16, 1'b0, 0, 0);
        wait_ic_words(2, "t4_two_words");
        rst = 1'b1;
        exp_words.delete();
        @(negedge clk);
        chk("t4_rst_ic_avail", 64'(ic_if.user_available), 64'd0);
        chk("t4_rst_mem_re", 64'(mem_if.user_re), 64'd0);
        chk("t4_rst_ic_done", 64'(ic_if.control_done), 64'd1);
        chk("t4_rst_dc_done", 64'(dc_if.control_done), 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("t4_post_ic_avail", 64'(ic_if.user_available), 64'd0);
            chk("t4_post_mem_re", 64'(mem_if.user_re), 64'd0);
            chk("t4_post_ic_done", 64'(ic_if.control_done), 64'd1);
            chk("t4_post_dc_done", 64'(dc_if.control_done), 64'd1);
            chk("t4_words_unconsumed", 64'(mem_if.user_available), 64'd1);
            @(posedge clk);
            #1;
        end
        mem_flush = 1'b1;
        @(posedge clk);
        #1 mem_flush = 1'b0;

        // Zero-length request is dropped
        pulse(1'b1, 'hA00, 0, 1'b0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("t5_ic_done_high", 64'(ic_if.control_done), 64'd1);
            chk("t5_no_mem_go", 64'(mem_if.control_go), 64'd0);
            @(posedge clk);
            #1;
        end

        // Memory busy holds off the issue
        mem_done = 1'b0;
        expect_burst(1'b0, 'h900, 4);
        pulse(1'b1, 'h900, 4, 1'b0, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("t6_no_issue", 64'(mem_if.control_go), 64'd0);
            chk("t6_ic_pending", 64'(ic_if.control_done), 64'd0);
            @(posedge clk);
            #1;
        end
        mem_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_issue_after_done", 64'(mem_if.control_go), 64'd1);
        wait_idle("t6");
        chk("final_issues_left", 64'(exp_iss.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
